// File: rtl/speed_meas_ctrl_pkg.sv
// Shared widths, defaults and FSM state type for the gate-timing speed meter and its divider.
// Declarations only: no logic, no latency.
package speed_pkg;
   localparam int unsigned DIVIDEND_W = 32;
   localparam int unsigned DIVISOR_W  = 24;
   localparam int unsigned DISP_W     = 14;

   localparam logic [DIVIDEND_W-1:0] SPEED_NUM_DEF   = 32'd36_000_000;
   localparam logic [DIVISOR_W-1:0]  TIMEOUT_CYC_DEF = 24'hFF_FFFF;
   localparam logic [DISP_W-1:0]     MAX_DISP_DEF    = 14'd9999;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TIMING   = 2'd1,
      DIV_REQ  = 2'd2,
      DIV_WAIT = 2'd3
   } state_t;
endpackage

// File: rtl/speed_meas_ctrl_if.sv
// Start/done handshake between the speed controller (master) and the sequential divider (slave).
// The master holds dividend/divisor from div_start until div_done; quotient is valid only in the div_done cycle.
interface speed_meas_ctrl_if;
   import speed_pkg::*;

   logic                  div_start;
   logic [DIVIDEND_W-1:0] div_dividend;
   logic [DIVISOR_W-1:0]  div_divisor;
   logic                  div_done;
   logic [DIVIDEND_W-1:0] div_quotient;

   modport master (
      output div_start, div_dividend, div_divisor,
      input  div_done, div_quotient
   );

   modport slave (
      input  div_start, div_dividend, div_divisor,
      output div_done, div_quotient
   );
endinterface

// File: rtl/speed_meas_ctrl_div.sv
// Restoring divider, 32-bit dividend / 24-bit divisor, one quotient bit per cycle.
// div_done pulses 32 cycles after div_start is sampled; a div_start while running is ignored.
module seq_divider
   import speed_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   speed_meas_ctrl_if.slave bus
);
   logic [DIVIDEND_W-1:0] quo;
   logic [DIVISOR_W-1:0]  rem;
   logic [DIVISOR_W-1:0]  dsr;
   logic [5:0]            cnt;
   logic                  run;
   logic [DIVISOR_W:0]    trial;

   // quo doubles as the dividend shift register: its MSB feeds the partial remainder
   assign trial            = {rem, quo[DIVIDEND_W-1]};
   assign bus.div_quotient = quo;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         quo          <= '0;
         rem          <= '0;
         dsr          <= '0;
         cnt          <= '0;
         run          <= 1'b0;
         bus.div_done <= 1'b0;
      end else begin
         bus.div_done <= 1'b0;
         if (bus.div_start && !run) begin
            quo <= bus.div_dividend;
            rem <= '0;
            dsr <= bus.div_divisor;
            cnt <= 6'd32;
            run <= 1'b1;
         end else if (run) begin
            // when trial >= dsr the true difference is below dsr, so the low bits are exact
            if (trial >= {1'b0, dsr}) begin
               rem <= trial[DIVISOR_W-1:0] - dsr;
               quo <= {quo[DIVIDEND_W-2:0], 1'b1};
            end else begin
               rem <= trial[DIVISOR_W-1:0];
               quo <= {quo[DIVIDEND_W-2:0], 1'b0};
            end
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) begin
               run          <= 1'b0;
               bus.div_done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/speed_meas_ctrl.sv
// Times start-gate to stop-gate and converts the period to a clamped display speed via an external divider.
// Sensor edges act 2 cycles after the input rises; result appears 1 cycle after div_done; edges are dropped while dividing.
module speed_meas_ctrl
   import speed_pkg::*;
#(
   parameter logic [DIVIDEND_W-1:0] SPEED_NUM   = SPEED_NUM_DEF,
   parameter logic [DIVISOR_W-1:0]  TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter logic [DISP_W-1:0]     MAX_DISP    = MAX_DISP_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sensor_a,
   input  logic              sensor_b,
   speed_meas_ctrl_if.master div,
   output logic [DISP_W-1:0] speed_value,
   output logic              speed_valid,
   output logic              overrange,
   output logic              timeout,
   output logic              busy
);
   logic [1:0]            sync_a, sync_b;
   logic                  prev_a, prev_b;
   logic                  edge_a, edge_b;
   state_t                state, state_nxt;
   logic [DIVISOR_W-1:0]  cnt, elapsed, divisor;
   logic                  at_limit;
   logic [DIVIDEND_W-1:0] max_wide;
   logic                  over;
   logic                  start;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
         prev_a <= 1'b0;
         prev_b <= 1'b0;
      end else begin
         sync_a <= {sync_a[0], sensor_a};
         sync_b <= {sync_b[0], sensor_b};
         prev_a <= sync_a[1];
         prev_b <= sync_b[1];
      end
   end

   assign edge_a = sync_a[1] & ~prev_a;
   assign edge_b = sync_b[1] & ~prev_b;

   // elapsed counts cycles since the start edge including this one, so a stop edge N cycles later sees N
   assign elapsed  = cnt + DIVISOR_W'(1);
   assign at_limit = (elapsed >= TIMEOUT_CYC);
   assign max_wide = {{(DIVIDEND_W-DISP_W){1'b0}}, MAX_DISP};
   assign over     = (div.div_quotient > max_wide);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (edge_a) state_nxt = TIMING;
         TIMING: begin
            if (at_limit)    state_nxt = IDLE;
            else if (edge_a) state_nxt = TIMING;
            else if (edge_b) state_nxt = DIV_REQ;
         end
         DIV_REQ:  state_nxt = DIV_WAIT;
         DIV_WAIT: if (div.div_done) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state != IDLE);
      start = (state == DIV_REQ);
   end

   assign div.div_start    = start;
   assign div.div_dividend = SPEED_NUM;
   assign div.div_divisor  = divisor;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt         <= '0;
         divisor     <= '0;
         speed_value <= '0;
         speed_valid <= 1'b0;
         overrange   <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         speed_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (edge_a) begin
                  cnt       <= '0;
                  overrange <= 1'b0;
                  timeout   <= 1'b0;
               end
            end
            TIMING: begin
               // timeout wins over a same-cycle stop edge; counter stops before it could wrap
               if (at_limit) begin
                  timeout     <= 1'b1;
                  speed_value <= '0;
                  speed_valid <= 1'b1;
               end else if (edge_a) begin
                  cnt <= '0;
               end else begin
                  cnt <= elapsed;
                  if (edge_b) divisor <= elapsed;
               end
            end
            DIV_WAIT: begin
               if (div.div_done) begin
                  speed_value <= over ? MAX_DISP : div.div_quotient[DISP_W-1:0];
                  overrange   <= over;
                  speed_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/speed_meas_ctrl.md
SPEED_MEAS_CTRL -- requirements
Module: speed_meas_ctrl

Interface
REQ-001 Parameter SPEED_NUM, default 36_000_000, SHALL be the speed numerator: speed = SPEED_NUM / period_cycles.
REQ-002 Parameter TIMEOUT_CYC, default 24'hFFFFFF, SHALL be the maximum period in cycles before a measurement is abandoned.
REQ-003 Parameter MAX_DISP, default 9999, SHALL be the largest displayable speed.
REQ-004 clk  in  1  single 12 MHz clock; all logic on posedge clk.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 sensor_a  in  1  raw asynchronous start-gate sensor.
REQ-007 sensor_b  in  1  raw asynchronous stop-gate sensor.
REQ-008 div_start  out  1  one-cycle request pulse to the divider.
REQ-009 div_dividend  out  32  equals SPEED_NUM, held constant.
REQ-010 div_divisor  out  24  captured period; stable from div_start until div_done.
REQ-011 div_done  in  1  one-cycle divider completion pulse.
REQ-012 div_quotient  in  32  quotient, valid in the div_done cycle.
REQ-013 speed_value  out  14  latched displayed speed, 0..MAX_DISP.
REQ-014 speed_valid  out  1  one-cycle pulse when speed_value updates.
REQ-015 overrange  out  1  sticky until the next measurement start; last quotient exceeded MAX_DISP.
REQ-016 timeout  out  1  sticky until the next measurement start; last measurement timed out.
REQ-017 busy  out  1  high in any state except IDLE.

Function
REQ-018 Each sensor SHALL pass through a 2-flop synchronizer followed by a rising-edge detector (sync & ~sync_d); both paths SHALL have identical latency.
REQ-019 The FSM SHALL have exactly the states IDLE, TIMING, DIV_REQ and DIV_WAIT.
REQ-020 IDLE: an edge on A SHALL go to TIMING, clear the period counter, and clear overrange and timeout; an edge on B SHALL be ignored.
REQ-021 TIMING: the counter SHALL increment once per cycle, so that a B edge N cycles after the A edge captures div_divisor = N.
REQ-022 TIMING: an A edge SHALL restart the counter from zero and remain in TIMING. An A edge and a B edge in the same cycle SHALL be treated as a restart.
REQ-023 TIMING: on a B edge the FSM SHALL go to DIV_REQ. When the counter reaches TIMEOUT_CYC, the FSM SHALL go to IDLE, set timeout, set speed_value to 0 and pulse speed_valid.
REQ-024 DIV_REQ: div_start SHALL be asserted for exactly one cycle, and the FSM SHALL then go to DIV_WAIT; div_start SHALL therefore rise one cycle after the B edge is detected.
REQ-025 DIV_WAIT: on div_done, speed_value SHALL be set to min(div_quotient, MAX_DISP), overrange SHALL be set if div_quotient > MAX_DISP, speed_valid SHALL pulse in the following cycle, and the FSM SHALL go to IDLE.
REQ-026 Sensor edges in DIV_REQ and DIV_WAIT SHALL be ignored and SHALL NOT be queued.
REQ-027 div_done outside DIV_WAIT SHALL be ignored.
REQ-028 The counter SHALL never wrap; the timeout check SHALL take priority over a same-cycle B edge.

Reset
REQ-029 On rst_n=0 at a clock edge, the following SHALL be cleared: state to IDLE; counter, div_divisor, speed_value, div_start, speed_valid, overrange, timeout, busy and synchronizer flops all to 0.
REQ-030 Reset mid-operation (any state) SHALL abandon the measurement without a speed_valid pulse; a div_done arriving after reset SHALL be ignored.

Structure
REQ-031 Shared package speed_pkg SHALL hold the state enum, SPEED_NUM, MAX_DISP, the default TIMEOUT_CYC and the width constants 32/24/14.
REQ-032 The divider SHALL be a separate sub-module seq_divider: an iterative restoring divider with a 32/24 start/done handshake, one quotient bit per cycle; the controller SHALL NOT contain it.
REQ-033 The existing seven-segment display SHALL consume speed_value unchanged.

Verification
REQ-034 A edge, then B edge 12000 cycles later -> div_divisor=12000, quotient 3000, speed_value=3000, overrange=0, one speed_valid pulse.
REQ-035 B edge 1200 cycles after A -> quotient 30000, speed_value=9999, overrange=1.
REQ-036 TIMEOUT_CYC=100 and no B edge -> timeout=1 and speed_value=0 after 100 cycles, then IDLE; a new A edge clears timeout.
REQ-037 A at t0, A again at t0+500, B at t0+4100 -> div_divisor=3600, speed_value=9999.
REQ-038 rst_n low for 1 cycle during DIV_WAIT, followed by a late div_done -> all outputs 0, state IDLE, no speed_valid pulse.
REQ-039 B edge alone in IDLE, and A/B edges during DIV_WAIT -> no state change and no div_start.
